// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Holds the inter-stage bus widths, the one-hot load_op bit indices and
// packed structs describing the layout of each bus (MSB-first field order).
package mem_stage_pkg;

    localparam int EXE_TO_MEM_LEN = 188;
    localparam int MEM_TO_WB_LEN  = 149;
    localparam int MEM_RF_LEN     = 54;
    localparam int DEST_LEN       = 5;
    localparam int LOAD_OP_W      = 5;
    localparam int CSR_NUM_W      = 14;

    // One-hot load_op bit positions
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    typedef struct packed {
        logic [31:0]           pc;
        logic                  gr_we;
        logic [DEST_LEN-1:0]   dest;
        logic [31:0]           exe_result;
        logic [31:0]           st_data;
        logic                  mem_en;
        logic [LOAD_OP_W-1:0]  load_op;
        logic                  rfrom_mem;
        logic [CSR_NUM_W-1:0]  csr_num;
        logic                  csr_we;
        logic [31:0]           csr_wvalue;
        logic [31:0]           csr_wmask;
    } exe_to_mem_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic                  gr_we;
        logic [DEST_LEN-1:0]   dest;
        logic [31:0]           final_result;
        logic [CSR_NUM_W-1:0]  csr_num;
        logic                  csr_we;
        logic [31:0]           csr_wvalue;
        logic [31:0]           csr_wmask;
    } mem_to_wb_t;

    typedef struct packed {
        logic [DEST_LEN-1:0]   dest;
        logic                  ld_pending;
        logic [31:0]           final_result;
        logic                  mem_valid;
        logic                  csr_we;
        logic [CSR_NUM_W-1:0]  csr_num;
    } mem_rf_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension (purely combinational).
//   word    : 32-bit SRAM word containing the addressed data
//   off     : byte offset within the word (address bits [1:0])
//   load_op : one-hot load type (LD_B/LD_H/LD_W/LD_BU/LD_HU)
//   result  : aligned, sign/zero-extended load value
// Halfword accesses use only off[1]; execute never passes misaligned
// halfword/word addresses, so the remaining low bits are ignored there.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]          word,
    input  logic [1:0]           off,
    input  logic [LOAD_OP_W-1:0] load_op,
    output logic [31:0]          result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path would infer a latch.
        byte_val = word[7:0];
        case (off)
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            2'd3:    byte_val = word[31:24];
            default: byte_val = word[7:0];
        endcase
        half_val = off[1] ? word[31:16] : word[15:0];

        result = word;
        if (load_op[LD_B])
            result = {{24{byte_val[7]}}, byte_val};
        else if (load_op[LD_BU])
            result = {24'h0, byte_val};
        else if (load_op[LD_H])
            result = {{16{half_val[15]}}, half_val};
        else if (load_op[LD_HU])
            result = {16'h0, half_val};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
//   clk, reset           : clock, synchronous active-high reset
//   exe_to_mem_valid/bus : instruction from execute; mem_allowin back-pressures
//   mem_to_wb_valid/bus  : result to writeback; wb_allowin back-pressures
//   mem_rf_bus           : forwarding / load-use hazard info for decode
//   data_sram_data_ok    : response strobe for a request issued in execute
//   data_sram_rdata      : response data, valid with data_ok
//   req_issued           : execute issued a request this cycle
//   wb_flush             : exception/ertn flush from writeback
// Loads and stores wait for their SRAM response. A response arriving while
// writeback stalls is held in a one-entry buffer. Responses still owed to
// squashed instructions are counted in drop_cnt and discarded on arrival.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DROP_CNT_W = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      exe_to_mem_valid,
    output logic                      mem_allowin,
    input  logic [EXE_TO_MEM_LEN-1:0] exe_to_mem_bus,
    output logic                      mem_to_wb_valid,
    input  logic                      wb_allowin,
    output logic [MEM_TO_WB_LEN-1:0]  mem_to_wb_bus,
    output logic [MEM_RF_LEN-1:0]     mem_rf_bus,
    input  logic                      data_sram_data_ok,
    input  logic [31:0]               data_sram_rdata,
    input  logic                      req_issued,
    input  logic                      wb_flush
);

    localparam int SUM_W = DROP_CNT_W + 1;

    exe_to_mem_t           payload_q, payload_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [31:0]           buf_data_q, buf_data_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic       need_resp, resp_ok, ready_go, leave, capture;
    logic       owed, squash, stale, drop_overflow;
    logic [SUM_W-1:0] drop_sum;
    logic [31:0] load_word, load_data, final_result;
    mem_to_wb_t wb_s;
    mem_rf_t    rf_s;
    logic       unused_st_data;

    // Stores wait for data_ok too, so both kinds of memory op need a response.
    assign need_resp = payload_q.mem_en || payload_q.rfrom_mem;
    // A response belongs to the current instruction only when nothing stale is owed.
    assign resp_ok   = data_sram_data_ok && (drop_cnt_q == '0);
    assign ready_go  = !need_resp || buf_valid_q || resp_ok;
    assign leave     = mem_valid_q && ready_go && wb_allowin;
    assign capture   = resp_ok && mem_valid_q && need_resp && !buf_valid_q;

    assign mem_allowin     = !mem_valid_q || (ready_go && wb_allowin);
    assign mem_to_wb_valid = mem_valid_q && ready_go && !wb_flush;

    always_comb begin
        mem_valid_d = mem_valid_q;
        payload_d   = payload_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;

        if (exe_to_mem_valid && mem_allowin)
            payload_d = exe_to_mem_bus;

        if (wb_flush)
            mem_valid_d = 1'b0;
        else if (mem_allowin)
            mem_valid_d = exe_to_mem_valid;

        if (capture)
            buf_data_d = data_sram_rdata;

        // Leaving in the capture cycle is the pass-through case: buffer stays clear.
        if (wb_flush || leave)
            buf_valid_d = 1'b0;
        else if (capture)
            buf_valid_d = 1'b1;
    end

    // Drop counter: a flushed instruction still waiting for its response, and
    // a request issued by execute in the flush cycle, each add one; every
    // stale data_ok removes one. The sum is one bit wider to detect overflow.
    assign owed   = wb_flush && mem_valid_q && need_resp && !buf_valid_q && !resp_ok;
    assign squash = wb_flush && req_issued;
    assign stale  = data_sram_data_ok && (drop_cnt_q != '0);

    always_comb begin
        drop_sum      = {1'b0, drop_cnt_q} + SUM_W'(owed) + SUM_W'(squash) - SUM_W'(stale);
        drop_overflow = drop_sum[DROP_CNT_W];
        drop_cnt_d    = drop_overflow ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            mem_valid_q <= 1'b0;
            payload_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            payload_q   <= payload_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    drop_cnt_no_overflow: assert property (@(posedge clk) disable iff (reset) !drop_overflow);

    assign load_word = buf_valid_q ? buf_data_q : data_sram_rdata;

    mem_load_align u_load_align (
        .word    (load_word),
        .off     (payload_q.exe_result[1:0]),
        .load_op (payload_q.load_op),
        .result  (load_data)
    );

    assign final_result = payload_q.rfrom_mem ? load_data : payload_q.exe_result;

    always_comb begin
        wb_s.pc           = payload_q.pc;
        wb_s.gr_we        = payload_q.gr_we;
        wb_s.dest         = payload_q.dest;
        wb_s.final_result = final_result;
        wb_s.csr_num      = payload_q.csr_num;
        wb_s.csr_we       = payload_q.csr_we;
        wb_s.csr_wvalue   = payload_q.csr_wvalue;
        wb_s.csr_wmask    = payload_q.csr_wmask;

        // ld_pending tells decode to stall rather than forward a result not yet here.
        rf_s.dest         = (payload_q.gr_we && mem_valid_q) ? payload_q.dest : '0;
        rf_s.ld_pending   = mem_valid_q && payload_q.rfrom_mem && !ready_go;
        rf_s.final_result = final_result;
        rf_s.mem_valid    = mem_valid_q;
        rf_s.csr_we       = payload_q.csr_we && mem_valid_q;
        rf_s.csr_num      = payload_q.csr_num;
    end

    assign mem_to_wb_bus = wb_s;
    assign mem_rf_bus    = rf_s;

    // Store data was consumed by the request in execute; it only rides along here.
    assign unused_st_data = ^payload_q.st_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-instruction vectors
// plus hand-written sequences for stalls, buffering, flush and stale drops.
// Retired results are compared against a scoreboard queue filled at issue.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      exe_to_mem_valid;
    logic                      mem_allowin;
    logic [EXE_TO_MEM_LEN-1:0] exe_to_mem_bus;
    logic                      mem_to_wb_valid;
    logic                      wb_allowin;
    logic [MEM_TO_WB_LEN-1:0]  mem_to_wb_bus;
    logic [MEM_RF_LEN-1:0]     mem_rf_bus;
    logic                      data_sram_data_ok;
    logic [31:0]               data_sram_rdata;
    logic                      req_issued;
    logic                      wb_flush;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .exe_to_mem_bus    (exe_to_mem_bus),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_rf_bus        (mem_rf_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .req_issued        (req_issued),
        .wb_flush          (wb_flush)
    );

    always #5 clk = ~clk;

    mem_rf_t    rf_s;
    mem_to_wb_t wb_s;
    assign rf_s = mem_rf_bus;
    assign wb_s = mem_to_wb_bus;

    int n_cmp = 0;
    int n_err = 0;
    int retire_cnt = 0;
    mem_to_wb_t sb_q[$];

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic        mem_en;
        logic        rfrom;
        logic [31:0] res;
        logic [31:0] rdata;
        int          gap;
        logic [31:0] expv;
    } vec_t;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_B    = 5'b10000;
    localparam logic [4:0] OP_H    = 5'b01000;
    localparam logic [4:0] OP_W    = 5'b00100;
    localparam logic [4:0] OP_BU   = 5'b00010;
    localparam logic [4:0] OP_HU   = 5'b00001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bus(input string name, input logic [MEM_TO_WB_LEN-1:0] act,
                             input logic [MEM_TO_WB_LEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Retire monitor: sampled mid-cycle, a transfer happens when valid && allowin.
    always @(negedge clk) begin
        if (!reset && mem_to_wb_valid && wb_allowin) begin
            retire_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_retire: got pc %0h expected none at %0t", wb_s.pc, $time);
            end else begin
                mem_to_wb_t e;
                e = sb_q.pop_front();
                check("final_result", wb_s.final_result, e.final_result);
                check_bus("retire_bus", mem_to_wb_bus, e);
            end
        end
    end

    // Drive one instruction; returns at posedge+1 after acceptance with the
    // instruction now held in the stage and its expected result queued.
    task automatic send(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                        input logic [4:0] op, input logic mem_en, input logic rfrom,
                        input logic [31:0] expv, output int waited);
        exe_to_mem_t b;
        mem_to_wb_t  e;
        logic        ok;
        b.pc = pc;             b.gr_we = 1'b1;          b.dest = dest;
        b.exe_result = res;    b.st_data = ~res;        b.mem_en = mem_en;
        b.load_op = op;        b.rfrom_mem = rfrom;     b.csr_num = pc[15:2];
        b.csr_we = pc[2];      b.csr_wvalue = res ^ 32'h5a5a_5a5a;
        b.csr_wmask = ~pc;
        e.pc = pc;             e.gr_we = 1'b1;          e.dest = dest;
        e.final_result = expv; e.csr_num = pc[15:2];    e.csr_we = pc[2];
        e.csr_wvalue = res ^ 32'h5a5a_5a5a;             e.csr_wmask = ~pc;
        exe_to_mem_bus   = b;
        exe_to_mem_valid = 1'b1;
        waited = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = mem_allowin;
            @(posedge clk);
            #1;
            if (!ok) begin
                waited++;
                if (waited > 50) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL accept_timeout: got no mem_allowin expected accept pc %0h", pc);
                    break;
                end
            end
        end
        exe_to_mem_valid = 1'b0;
        if (ok) sb_q.push_back(e);
    endtask

    // Respond 'gap' cycles after the instruction entered the stage.
    task automatic resp(input int gap, input logic [31:0] data);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = data;
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BAD_0BAD;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        int   w;
        int   base;

        vecs[0]  = '{"alu",       OP_NONE, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         0, 32'h0000_1234};
        vecs[1]  = '{"ld_b_o0",   OP_B,    1'b1, 1'b1, 32'h1000_0000, 32'h1234_56F0, 0, 32'hFFFF_FFF0};
        vecs[2]  = '{"ld_b_o1",   OP_B,    1'b1, 1'b1, 32'h1000_0001, 32'h0000_7F00, 1, 32'h0000_007F};
        vecs[3]  = '{"ld_bu_o1",  OP_BU,   1'b1, 1'b1, 32'h1000_0005, 32'h1234_AB78, 0, 32'h0000_00AB};
        vecs[4]  = '{"ld_bu_o2",  OP_BU,   1'b1, 1'b1, 32'h1000_0002, 32'h127F_0000, 2, 32'h0000_007F};
        vecs[5]  = '{"ld_hu_o2",  OP_HU,   1'b1, 1'b1, 32'h1000_0002, 32'hBEEF_0000, 0, 32'h0000_BEEF};
        vecs[6]  = '{"ld_h_o2",   OP_H,    1'b1, 1'b1, 32'h1000_0002, 32'hBEEF_0000, 1, 32'hFFFF_BEEF};
        vecs[7]  = '{"ld_h_o0",   OP_H,    1'b1, 1'b1, 32'h1000_0008, 32'h0000_8001, 0, 32'hFFFF_8001};
        vecs[8]  = '{"ld_hu_o0",  OP_HU,   1'b1, 1'b1, 32'h1000_000C, 32'h1234_7FFF, 0, 32'h0000_7FFF};
        vecs[9]  = '{"ld_w",      OP_W,    1'b1, 1'b1, 32'h1000_0010, 32'hCAFE_F00D, 3, 32'hCAFE_F00D};
        vecs[10] = '{"store",     OP_NONE, 1'b1, 1'b0, 32'h2000_0004, 32'h5555_5555, 1, 32'h2000_0004};
        vecs[11] = '{"alu_neg",   OP_NONE, 1'b0, 1'b0, 32'h8000_0001, 32'h0,         0, 32'h8000_0001};

        reset = 1'b1;
        exe_to_mem_valid = 1'b0;
        exe_to_mem_bus = '0;
        wb_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        req_issued = 1'b0;
        wb_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_allowin", 32'(mem_allowin), 32'd1);
        check("rst_wb_valid", 32'(mem_to_wb_valid), 32'd0);
        check("rst_rf_valid", 32'(rf_s.mem_valid), 32'd0);
        @(posedge clk);
        #1;

        // Table-driven single instructions
        foreach (vecs[i]) begin
            send(32'h1c00_0000 + 32'(i * 4), 5'(i + 1), vecs[i].res, vecs[i].op,
                 vecs[i].mem_en, vecs[i].rfrom, vecs[i].expv, w);
            if (vecs[i].mem_en || vecs[i].rfrom) resp(vecs[i].gap, vecs[i].rdata);
            drain(vecs[i].name);
        end

        // LD_B at offset 3, response two cycles late: ld_pending until data_ok
        send(32'h1c00_0100, 5'd7, 32'h1000_0003, OP_B, 1'b1, 1'b1, 32'hFFFF_FF80, w);
        @(negedge clk);
        check("ldb_pending_c1", 32'(rf_s.ld_pending), 32'd1);
        check("ldb_rf_dest", 32'(rf_s.dest), 32'd7);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ldb_pending_c2", 32'(rf_s.ld_pending), 32'd1);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        check("ldb_pending_done", 32'(rf_s.ld_pending), 32'd0);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        drain("ldb_late");

        // LD_W answered while writeback stalls for 3 cycles: result buffered
        wb_allowin = 1'b0;
        send(32'h1c00_0200, 5'd9, 32'h1000_0020, OP_W, 1'b1, 1'b1, 32'hCAFE_F00D, w);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("buf_c1_valid", 32'(mem_to_wb_valid), 32'd1);
        check("buf_c1_allowin", 32'(mem_allowin), 32'd0);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0BAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("buf_hold_valid", 32'(mem_to_wb_valid), 32'd1);
            check("buf_hold_result", rf_s.final_result, 32'hCAFE_F00D);
            @(posedge clk);
            #1;
        end
        wb_allowin = 1'b1;
        drain("buffered");

        // Flush while a load waits: its response must be dropped
        send(32'h1c00_0300, 5'd10, 32'h1000_0030, OP_W, 1'b1, 1'b1, 32'h0, w);
        void'(sb_q.pop_back());
        wb_flush = 1'b1;
        @(negedge clk);
        check("flush_no_retire", 32'(mem_to_wb_valid), 32'd0);
        @(posedge clk);
        #1;
        wb_flush = 1'b0;
        @(negedge clk);
        check("flush_rf_valid", 32'(rf_s.mem_valid), 32'd0);
        check("flush_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        @(posedge clk);
        #1;
        send(32'h1c00_0304, 5'd11, 32'h1000_0031, OP_BU, 1'b1, 1'b1, 32'h0000_00A5, w);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        check("stale_no_retire", 32'(mem_to_wb_valid), 32'd0);
        check("stale_pending", 32'(rf_s.ld_pending), 32'd1);
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h0000_A500;
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        drain("after_drop");
        check("drop_cnt_clear", 32'(dut.drop_cnt_q), 32'd0);

        // Flush with an owed response and a squashed request: +2, then a
        // flush+req coinciding with a stale response keeps the count
        send(32'h1c00_0400, 5'd12, 32'h1000_0040, OP_W, 1'b1, 1'b1, 32'h0, w);
        void'(sb_q.pop_back());
        wb_flush = 1'b1;
        req_issued = 1'b1;
        @(posedge clk);
        #1;
        req_issued = 1'b0;
        wb_flush = 1'b0;
        @(negedge clk);
        check("drop_cnt_two", 32'(dut.drop_cnt_q), 32'd2);
        @(posedge clk);
        #1;
        wb_flush = 1'b1;
        req_issued = 1'b1;
        data_sram_data_ok = 1'b1;
        @(posedge clk);
        #1;
        wb_flush = 1'b0;
        req_issued = 1'b0;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("drop_cnt_inc_dec", 32'(dut.drop_cnt_q), 32'd2);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("drop_cnt_drained", 32'(dut.drop_cnt_q), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back ALU ops: one retire per cycle, never back-pressured
        base = retire_cnt;
        for (int k = 0; k < 4; k++) begin
            send(32'h1c00_0500 + 32'(k * 4), 5'(20 + k), 32'h0000_0100 + 32'(k), OP_NONE,
                 1'b0, 1'b0, 32'h0000_0100 + 32'(k), w);
            check("b2b_no_wait", 32'(w), 32'd0);
        end
        drain("b2b");
        check("b2b_retires", 32'(retire_cnt - base), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
